// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative 32-bit multiply/divide unit feeding the register file write port.
// One MULTU/MULT/DIVU/DIV operation is accepted at a time. The operation takes
// a fixed 34 cycles from the accept edge to the DONE cycle, and then a single
// one-cycle register write of the selected result half is issued.
//
// Build option:
//   MULDIV_DIV_EN  defined   -> restoring divider present (DIVU/DIV computed)
//                  undefined -> no divide datapath; DIVU/DIV go straight to
//                               DONE with hi=lo=0, WEN=0 and div0=1
//
// Ports:
//   CLK     in   1  clock, rising edge
//   nRST    in   1  asynchronous active-low reset
//   start   in   1  request, accepted only in IDLE
//   op      in   2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opA     in  32  multiplicand / dividend (sampled at accept)
//   opB     in  32  multiplier / divisor (sampled at accept)
//   dest    in   5  destination register (sampled at accept)
//   hi_sel  in   1  1: write back HI, 0: write back LO (sampled at accept)
//   flush   in   1  synchronous abort, beats start
//   busy    out  1  not IDLE
//   done    out  1  one-cycle completion pulse
//   WEN     out  1  register file write enable (dest != 0)
//   wsel    out  5  register file write select
//   wdat    out 32  register file write data
//   hi      out 32  product[63:32] / remainder
//   lo      out 32  product[31:0]  / quotient
//   div0    out  1  divide-by-zero flag, valid with done
// ----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  dest,
  input  logic        hi_sel,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Control strobes derived from the state machine
  logic w_accept;   // operands latched this edge
  logic w_iter;     // one multiply/divide step this edge
  logic w_finish;   // FIX -> DONE: results loaded this edge

  // Sequencing
  logic [4:0]  r_cnt;
  logic        r_warm;     // first CALC cycle after accept, no step taken
  logic [4:0]  r_dest;
  logic        r_hi_sel;
  logic        r_neg_lo;   // negate product (MULT) or quotient (DIV)

  // Multiply datapath
  logic [31:0] r_mcand;
  logic [63:0] r_acc;      // {partial product, remaining multiplier bits}
  logic [32:0] w_madd;

  // Operand magnitudes and signs at accept
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  // Result correction
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  // Registered write-back outputs
  logic        r_done;
  logic        r_wen;
  logic [4:0]  r_wsel;
  logic [31:0] r_wdat;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div0_out;

`ifdef MULDIV_DIV_EN
  // Divide datapath
  logic        r_is_div;
  logic        r_neg_hi;   // remainder takes the dividend sign
  logic        r_div0;     // divisor was zero at accept
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quo;      // dividend bits shift out as quotient bits shift in
  logic [32:0] w_shift;    // 33-bit partial remainder for this step
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
`endif

  // --------------------------------------------------------------------------
  // Operand preparation
  // --------------------------------------------------------------------------
  always_comb begin
    w_sign_a = op[0] & opA[31];
    w_sign_b = op[0] & opB[31];
    w_abs_a  = w_sign_a ? (32'd0 - opA) : opA;
    w_abs_b  = w_sign_b ? (32'd0 - opB) : opB;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_iter       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
`ifdef MULDIV_DIV_EN
          w_state_next = CALC;
`else
          // Without a divider a divide completes immediately as div0.
          w_state_next = op[1] ? DONE : CALC;
`endif
        end
      end
      CALC: begin
        if (!r_warm) begin
          w_iter = 1'b1;
          if (r_cnt == 5'd31) begin
            w_state_next = FIX;
          end
        end
      end
      FIX: begin
        w_finish     = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Abort wins over everything, including a start in IDLE.
    if (flush) begin
      w_state_next = IDLE;
      w_accept     = 1'b0;
      w_iter       = 1'b0;
      w_finish     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Step logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_madd = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  end

`ifdef MULDIV_DIV_EN
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_ge    = (w_shift >= {1'b0, r_divisor});
    // When w_ge holds the true difference is below the divisor, so the
    // 32-bit wrapped subtraction is exact.
    w_sub   = w_shift[31:0] - r_divisor;
  end
`endif

  // --------------------------------------------------------------------------
  // Sequencing and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= 5'd0;
      r_warm    <= 1'b0;
      r_dest    <= 5'd0;
      r_hi_sel  <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_mcand   <= 32'd0;
      r_acc     <= 64'd0;
`ifdef MULDIV_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_div0    <= 1'b0;
      r_divisor <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
`endif
    end else if (w_accept) begin
      r_cnt     <= 5'd0;
      r_warm    <= 1'b1;
      r_dest    <= dest;
      r_hi_sel  <= hi_sel;
      r_neg_lo  <= w_sign_a ^ w_sign_b;
      r_mcand   <= w_abs_a;
      r_acc     <= {32'd0, w_abs_b};
`ifdef MULDIV_DIV_EN
      r_is_div  <= op[1];
      r_neg_hi  <= w_sign_a;
      r_div0    <= op[1] & (opB == 32'd0);
      r_divisor <= w_abs_b;
      r_rem     <= 32'd0;
      r_quo     <= w_abs_a;
`endif
    end else if (r_state == CALC && r_warm) begin
      r_warm <= 1'b0;
    end else if (w_iter) begin
      r_cnt <= r_cnt + 5'd1;
`ifdef MULDIV_DIV_EN
      if (r_is_div) begin
        r_rem <= w_ge ? w_sub : w_shift[31:0];
        r_quo <= {r_quo[30:0], w_ge};
      end else begin
        r_acc <= {w_madd, r_acc[31:1]};
      end
`else
      r_acc <= {w_madd, r_acc[31:1]};
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Sign correction (FIX)
  // --------------------------------------------------------------------------
  always_comb begin
    w_prod = r_neg_lo ? (64'd0 - r_acc) : r_acc;
`ifdef MULDIV_DIV_EN
    // With a zero divisor the divider naturally yields an all-ones quotient
    // and leaves |dividend| in the remainder; re-applying the dividend sign
    // to that remainder reproduces the raw dividend (0x80000000 included).
    w_quo_fix = r_div0 ? 32'hFFFF_FFFF : (r_neg_lo ? (32'd0 - r_quo) : r_quo);
    w_rem_fix = r_neg_hi ? (32'd0 - r_rem) : r_rem;
    w_fix_hi  = r_is_div ? w_rem_fix : w_prod[63:32];
    w_fix_lo  = r_is_div ? w_quo_fix : w_prod[31:0];
`else
    w_fix_hi  = w_prod[63:32];
    w_fix_lo  = w_prod[31:0];
`endif
  end

  // --------------------------------------------------------------------------
  // Result and write-back registers. The write-back fields are loaded on
  // entry to DONE and fall back to zero on the following edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_done     <= 1'b0;
      r_wen      <= 1'b0;
      r_wsel     <= 5'd0;
      r_wdat     <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_div0_out <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_wen      <= 1'b0;
      r_wsel     <= 5'd0;
      r_wdat     <= 32'd0;
      r_div0_out <= 1'b0;
      if (w_finish) begin
        r_done     <= 1'b1;
        r_wen      <= (r_dest != 5'd0);
        r_wsel     <= r_dest;
        r_wdat     <= r_hi_sel ? w_fix_hi : w_fix_lo;
        r_hi       <= w_fix_hi;
        r_lo       <= w_fix_lo;
`ifdef MULDIV_DIV_EN
        r_div0_out <= r_div0;
`endif
      end
`ifndef MULDIV_DIV_EN
      else if (w_accept && op[1]) begin
        r_done     <= 1'b1;
        r_wen      <= 1'b0;
        r_wsel     <= dest;
        r_wdat     <= 32'd0;
        r_hi       <= 32'd0;
        r_lo       <= 32'd0;
        r_div0_out <= 1'b1;
      end
`endif
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign WEN  = r_wen;
  assign wsel = r_wsel;
  assign wdat = r_wdat;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign div0 = r_div0_out;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Testbench for muldiv_unit. Table of operations with hand-derived results,
// a scoreboard queue checked whenever done pulses, and short sequences for
// mid-CALC start, flush and asynchronous reset.
module tb_muldiv_unit;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  dest;
  logic        hi_sel;
  logic        flush;
  logic        busy;
  logic        done;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  muldiv_unit dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .start  (start),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .dest   (dest),
    .hi_sel (hi_sel),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .WEN    (WEN),
    .wsel   (wsel),
    .wdat   (wdat),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        hs;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        ediv0;
  } vec_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] wdat;
    logic [4:0]  wsel;
    logic        wen;
    logic        div0;
  } exp_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t mon_e;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse pops one expected record.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb_q.pop_front();
        chk32("hi",   hi,            mon_e.hi);
        chk32("lo",   lo,            mon_e.lo);
        chk32("wdat", wdat,          mon_e.wdat);
        chk32("wsel", 32'(wsel),     32'(mon_e.wsel));
        chk32("WEN",  32'(WEN),      32'(mon_e.wen));
        chk32("div0", 32'(div0),     32'(mon_e.div0));
        $display("TXN id=%0d hi=%08h lo=%08h WEN=%b wsel=%0d wdat=%08h div0=%b",
                 mon_e.id, hi, lo, WEN, wsel, wdat, div0);
      end
    end
  end

  // Drive one operation, push its expectation, and measure edges from the
  // accept edge E0 to the first cycle in which done is seen.
  task automatic run_op(input vec_t v, input int pulse_at, input logic [7:0] id);
    exp_t e;
    int   n;
    int   lat;
    e.id   = id;
    e.hi   = v.ehi;
    e.lo   = v.elo;
    e.div0 = v.ediv0;
    e.wsel = v.dest;
    e.wen  = (v.dest != 5'd0);
    lat    = 34;
`ifndef MULDIV_DIV_EN
    if (v.op[1]) begin
      e.hi   = 32'd0;
      e.lo   = 32'd0;
      e.div0 = 1'b1;
      e.wen  = 1'b0;
      lat    = 0;
    end
`endif
    e.wdat = v.hs ? e.hi : e.lo;
    @(negedge CLK);
    start  = 1'b1;
    op     = v.op;
    opA    = v.a;
    opB    = v.b;
    dest   = v.dest;
    hi_sel = v.hs;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    start = 1'b0;
    n = 0;
    chk32("busy_after_accept", 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 60) begin
      if (pulse_at > 0 && n == pulse_at) begin
        start = 1'b1;
        op    = 2'b00;
        opA   = 32'h0000_1234;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK);
      #1;
      n++;
    end
    start = 1'b0;
    chk32("latency", 32'(n), 32'(lat));
    @(posedge CLK);
    #1;
    chk32("idle_after_done", 32'({busy, done, WEN}), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   dc0;
    vec_t v;

    //            op     opA           opB           dest  hs    hi            lo            div0
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 5'd8,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         5'd10, 1'b1, 32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b10, 32'd5,         32'd0,         5'd12, 1'b1, 32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'hFFFF_FFF8, 32'd0,         5'd13, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd14, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b01, 32'h0000_3039, 32'hFFFF_FFFF, 5'd15, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_CFC7, 1'b0};
    vecs[9]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 5'd31, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 5'd1,  1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd2,  1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};

    nRST   = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    opA    = 32'd0;
    opB    = 32'd0;
    dest   = 5'd0;
    hi_sel = 1'b0;
    flush  = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk32("reset_ctrl", 32'({busy, done, WEN, div0, wsel}), 32'd0);
    chk32("reset_wdat", wdat, 32'd0);
    chk32("reset_hi",   hi,   32'd0);
    chk32("reset_lo",   lo,   32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i], (i == 1) ? 10 : 0, 8'(i));
      if (i == 1) begin
        // The start pulsed during CALC must not produce a second result.
        dc0 = done_count;
        repeat (40) @(posedge CLK);
        chk32("no_second_done", 32'(done_count), 32'(dc0));
      end
    end

    // dest=0: result lands in hi/lo but no register write.
    v = '{2'b00, 32'd3, 32'd4, 5'd0, 1'b0, 32'd0, 32'd12, 1'b0};
    run_op(v, 0, 8'd20);

    // Flush during CALC: no completion, hi/lo untouched.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; opA = 32'd5; opB = 32'd6; dest = 5'd7; hi_sel = 1'b0;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    $display("TXN flush_abort busy=%b", busy);
    chk32("flush_busy", 32'({busy, done}), 32'd0);
    dc0 = done_count;
    repeat (45) @(posedge CLK);
    #1;
    chk32("flush_no_done", 32'(done_count), 32'(dc0));
    chk32("flush_hi_keep", hi, 32'd0);
    chk32("flush_lo_keep", lo, 32'd12);

    // Flush and start together in IDLE: flush wins.
    @(negedge CLK);
    start = 1'b1; flush = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0; flush = 1'b0;
    chk32("flush_beats_start", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; opA = 32'd7; opB = 32'd9; dest = 5'd4; hi_sel = 1'b0;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    $display("TXN reset_mid_calc busy=%b lo=%08h", busy, lo);
    chk32("rst_ctrl", 32'({busy, done, WEN, div0, wsel}), 32'd0);
    chk32("rst_wdat", wdat, 32'd0);
    chk32("rst_hi",   hi,   32'd0);
    chk32("rst_lo",   lo,   32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    v = '{2'b00, 32'd2, 32'd3, 5'd3, 1'b0, 32'd0, 32'd6, 1'b0};
    run_op(v, 0, 8'd21);

    repeat (5) @(posedge CLK);
    chk32("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
